// File: rtl/dadd_pkg.sv
// Shared types and constants for the dadd built-in self-test engine.
// The expected-beat struct here is sized for the default 32-bit dadd datapath.
package dadd_pkg;

    localparam int ADDR_STRIDE = 4;
    localparam int ERR_CNT_W   = 16;
    localparam int DADD_AW     = 32;
    localparam int DADD_DW     = 32;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef struct packed {
        logic [DADD_DW-1:0] data;
        logic [DADD_AW-1:0] addr;
    } exp_beat_t;

    // Error counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/dadd_drv_chk_if.sv
// Command channel plus both dadd beat channels of the self-test engine.
// master is the engine side, slave is the command source and dadd side.
interface dadd_drv_chk_if #(
    parameter int AWIDTH = 32,
    parameter int DWIDTH = 32,
    parameter int LEN_W  = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AWIDTH-1:0] cmd_addr;
    logic [DWIDTH-1:0] cmd_data;
    logic [LEN_W-1:0]  cmd_len;
    logic              dadd_in_en;
    logic [DWIDTH-1:0] dadd_in;
    logic [AWIDTH-1:0] dadd_in_addr;
    logic              dadd_out_en;
    logic [DWIDTH-1:0] dadd_out;
    logic [AWIDTH-1:0] dadd_out_addr;

    modport master (
        input  cmd_valid, cmd_addr, cmd_data, cmd_len,
        input  dadd_out_en, dadd_out, dadd_out_addr,
        output cmd_ready, dadd_in_en, dadd_in, dadd_in_addr
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_data, cmd_len,
        output dadd_out_en, dadd_out, dadd_out_addr,
        input  cmd_ready, dadd_in_en, dadd_in, dadd_in_addr
    );
endinterface

// File: rtl/dadd_exp_fifo.sv
// Small synchronous FIFO of expected beats; head is visible combinationally so
// the checker can compare in the same cycle a response arrives.
module dadd_exp_fifo
    import dadd_pkg::*;
#(
    parameter int  DEPTH  = 4,
    parameter type item_t = exp_beat_t
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   push,
    input  item_t                  push_item,
    input  logic                   pop,
    output item_t                  head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PTR_W = $clog2(DEPTH);

    item_t              mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W:0]     count_reg;
    logic               do_push;
    logic               do_pop;

    assign full    = (count_reg == (PTR_W+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_item;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end
endmodule

// File: rtl/dadd_drv_chk.sv
// Burst initiator and in-order response checker for the dadd increment datapath.
// Beat 0 is launched on the accept edge so the burst streams with no bubble.
module dadd_drv_chk
    import dadd_pkg::*;
#(
    parameter int AWIDTH     = 32,
    parameter int DWIDTH     = 32,
    parameter int LEN_W      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dadd_drv_chk_if.master       bus,
    output logic                 busy,
    output logic                 done,
    output logic                 timeout_err,
    output logic [ERR_CNT_W-1:0] err_cnt
);
    typedef struct packed {
        logic [DWIDTH-1:0] data;
        logic [AWIDTH-1:0] addr;
    } beat_t;

    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    state_t                 state_reg;
    logic                   cmd_ready_reg;
    logic                   busy_reg;
    logic                   done_reg;
    logic                   timeout_err_reg;
    logic [ERR_CNT_W-1:0]   err_cnt_reg;
    logic                   in_en_reg;
    logic [DWIDTH-1:0]      in_data_reg;
    logic [AWIDTH-1:0]      in_addr_reg;
    logic [DWIDTH-1:0]      base_data_reg;
    logic [AWIDTH-1:0]      base_addr_reg;
    logic [LEN_W-1:0]       len_reg;
    logic [LEN_W-1:0]       beat_reg;
    logic [TMO_W-1:0]       tmo_cnt_reg;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;
    beat_t                  fifo_head;
    beat_t                  push_item;

    logic                   accept;
    logic                   issue;
    logic                   last_beat;
    logic                   tmo_active;
    logic                   tmo_hit;
    logic                   chk_err;
    logic                   drain_done;
    logic [DWIDTH-1:0]      beat_data;
    logic [AWIDTH-1:0]      beat_addr;

    assign accept = (state_reg == ST_IDLE) && bus.cmd_valid;

    // In IDLE the beat comes straight from the command; afterwards from the latched base.
    always_comb begin
        beat_data = bus.cmd_data;
        beat_addr = bus.cmd_addr;
        last_beat = (bus.cmd_len == LEN_W'(1));
        if (state_reg != ST_IDLE) begin
            beat_data = base_data_reg + DWIDTH'(beat_reg);
            beat_addr = base_addr_reg + AWIDTH'(beat_reg) * AWIDTH'(ADDR_STRIDE);
            last_beat = (beat_reg == len_reg - LEN_W'(1));
        end
    end

    assign tmo_active = ((state_reg == ST_ISSUE) || (state_reg == ST_DRAIN))
                        && !fifo_empty && !bus.dadd_out_en;
    assign tmo_hit    = tmo_active && (tmo_cnt_reg == TMO_W'(TIMEOUT - 1));
    assign issue      = !tmo_hit && ((accept && (bus.cmd_len != '0))
                                     || ((state_reg == ST_ISSUE) && !fifo_full));
    assign push_item  = '{data: beat_data + DWIDTH'(1), addr: beat_addr};
    assign chk_err    = bus.dadd_out_en && (fifo_empty
                        || (fifo_head.data != bus.dadd_out)
                        || (fifo_head.addr != bus.dadd_out_addr));
    // Finish draining on the edge that retires the last outstanding beat.
    assign drain_done = bus.dadd_out_en ? (fifo_count == CNT_W'(1)) : fifo_empty;

    dadd_exp_fifo #(
        .DEPTH  (FIFO_DEPTH),
        .item_t (beat_t)
    ) u_exp_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (tmo_hit),
        .push      (issue),
        .push_item (push_item),
        .pop       (bus.dadd_out_en),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            cmd_ready_reg   <= 1'b1;
            busy_reg        <= 1'b0;
            done_reg        <= 1'b0;
            timeout_err_reg <= 1'b0;
            err_cnt_reg     <= '0;
            in_en_reg       <= 1'b0;
            in_data_reg     <= '0;
            in_addr_reg     <= '0;
            base_data_reg   <= '0;
            base_addr_reg   <= '0;
            len_reg         <= '0;
            beat_reg        <= '0;
            tmo_cnt_reg     <= '0;
        end else begin
            done_reg  <= 1'b0;
            in_en_reg <= issue;
            if (issue) begin
                in_data_reg <= beat_data;
                in_addr_reg <= beat_addr;
            end
            if (chk_err) err_cnt_reg <= sat_inc(err_cnt_reg);
            if (bus.dadd_out_en || tmo_hit) tmo_cnt_reg <= '0;
            else if (tmo_active)            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;

            case (state_reg)
                ST_IDLE: if (accept) begin
                    base_data_reg   <= bus.cmd_data;
                    base_addr_reg   <= bus.cmd_addr;
                    len_reg         <= bus.cmd_len;
                    beat_reg        <= LEN_W'(1);
                    err_cnt_reg     <= '0;
                    timeout_err_reg <= 1'b0;
                    tmo_cnt_reg     <= '0;
                    cmd_ready_reg   <= 1'b0;
                    busy_reg        <= 1'b1;
                    if (bus.cmd_len == '0) begin
                        state_reg <= ST_DONE;
                        done_reg  <= 1'b1;
                    end else if (last_beat) begin
                        state_reg <= ST_DRAIN;
                    end else begin
                        state_reg <= ST_ISSUE;
                    end
                end
                ST_ISSUE: if (tmo_hit) begin
                    state_reg       <= ST_DONE;
                    done_reg        <= 1'b1;
                    timeout_err_reg <= 1'b1;
                end else if (issue) begin
                    beat_reg <= beat_reg + 1'b1;
                    if (last_beat) state_reg <= ST_DRAIN;
                end
                ST_DRAIN: if (tmo_hit) begin
                    state_reg       <= ST_DONE;
                    done_reg        <= 1'b1;
                    timeout_err_reg <= 1'b1;
                end else if (drain_done) begin
                    state_reg <= ST_DONE;
                    done_reg  <= 1'b1;
                end
                ST_DONE: begin
                    state_reg     <= ST_IDLE;
                    cmd_ready_reg <= 1'b1;
                    busy_reg      <= 1'b0;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready    = cmd_ready_reg;
    assign bus.dadd_in_en   = in_en_reg;
    assign bus.dadd_in      = in_data_reg;
    assign bus.dadd_in_addr = in_addr_reg;
    assign busy             = busy_reg;
    assign done             = done_reg;
    assign timeout_err      = timeout_err_reg;
    assign err_cnt          = err_cnt_reg;
endmodule

// File: tb/tb_dadd_drv_chk.sv
// Directed bench for dadd_drv_chk against a latency-1 dadd model that can
// hold back, drop or corrupt responses.
module tb_dadd_drv_chk;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic        done;
    logic        timeout_err;
    logic [15:0] err_cnt;

    logic        hold;
    logic        drop;
    logic        corrupt_en;
    logic [31:0] corrupt_val;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int issued = 0;

    always #5 clk = ~clk;

    dadd_drv_chk_if #(.AWIDTH(32), .DWIDTH(32), .LEN_W(8)) bus ();

    dadd_drv_chk #(
        .AWIDTH(32), .DWIDTH(32), .LEN_W(8), .FIFO_DEPTH(4), .TIMEOUT(16)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (bus),
        .busy        (busy),
        .done        (done),
        .timeout_err (timeout_err),
        .err_cnt     (err_cnt)
    );

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] a;
    } rsp_t;
    rsp_t q[$];
    rsp_t r;

    // dadd model: out = in + 1, address passes through, one response per cycle.
    always @(posedge clk) begin
        if (!rst_n) begin
            q.delete();
            bus.dadd_out_en   <= 1'b0;
            bus.dadd_out      <= '0;
            bus.dadd_out_addr <= '0;
        end else begin
            if (bus.dadd_in_en && !drop)
                q.push_back('{(bus.dadd_in + 32'd1) ^
                              ((corrupt_en && bus.dadd_in == corrupt_val) ? 32'h100 : 32'h0),
                              bus.dadd_in_addr});
            if (!hold && q.size() > 0) begin
                r = q.pop_front();
                bus.dadd_out_en   <= 1'b1;
                bus.dadd_out      <= r.d;
                bus.dadd_out_addr <= r.a;
            end else begin
                bus.dadd_out_en <= 1'b0;
            end
        end
    end

    always @(posedge clk) if (bus.dadd_in_en) issued++;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
    endtask

    // Drive a command at a negedge; returns at the negedge of cycle 1.
    task automatic send(input logic [31:0] a, input logic [31:0] d, input logic [7:0] l);
        chk("send_ready", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = a;
        bus.cmd_data  = d;
        bus.cmd_len   = l;
        @(negedge clk);
        cyc = 1;
        bus.cmd_valid = 1'b0;
        $display("cmd addr=%0h data=%0h len=%0d", a, d, l);
    endtask

    task automatic wait_done(output int at);
        at = -1;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                at = cyc;
                break;
            end
            tick();
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_ready"}, bus.cmd_ready, 1);
        chk({tag, "_busy"},  busy, 0);
        chk({tag, "_done"},  done, 0);
        chk({tag, "_tmo"},   timeout_err, 0);
        chk({tag, "_err"},   err_cnt, 0);
        chk({tag, "_en"},    bus.dadd_in_en, 0);
        chk({tag, "_data"},  bus.dadd_in, 0);
        chk({tag, "_addr"},  bus.dadd_in_addr, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        int base;
        int dn;
        logic [31:0] wrap_d [3];
        wrap_d[0] = 32'hFFFF_FFFE;
        wrap_d[1] = 32'hFFFF_FFFF;
        wrap_d[2] = 32'h0000_0000;

        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.cmd_len   = '0;
        hold = 1'b0; drop = 1'b0; corrupt_en = 1'b0; corrupt_val = '0;
        repeat (3) @(negedge clk);
        chk_reset_outs("rst");
        rst_n = 1'b1;
        @(negedge clk);

        // Basic burst: beats 0x10..0x13 at 0x100 + 4*i, done in cycle 6.
        send(32'h100, 32'h10, 8'd4);
        chk("t1_busy", busy, 1);
        for (int i = 0; i < 4; i++) begin
            chk("t1_en", bus.dadd_in_en, 1);
            chk("t1_data", bus.dadd_in, 32'h10 + i);
            chk("t1_addr", bus.dadd_in_addr, 32'h100 + 4 * i);
            tick();
        end
        chk("t1_en_off", bus.dadd_in_en, 0);
        chk("t1_no_early_done", done, 0);
        wait_done(at);
        chk("t1_done_cyc", at, 6);
        chk("t1_err", err_cnt, 0);
        chk("t1_tmo", timeout_err, 0);
        tick();
        chk("t1_ready_back", bus.cmd_ready, 1);
        chk("t1_done_pulse", done, 0);
        chk("t1_idle", busy, 0);

        // Data wrap-around.
        send(32'h200, 32'hFFFF_FFFE, 8'd3);
        for (int i = 0; i < 3; i++) begin
            chk("t2_en", bus.dadd_in_en, 1);
            chk("t2_data", bus.dadd_in, wrap_d[i]);
            tick();
        end
        wait_done(at);
        chk("t2_done_cyc", at, 5);
        chk("t2_err", err_cnt, 0);
        tick();

        // Fault injection on beat 2 (data 0x22).
        corrupt_en = 1'b1; corrupt_val = 32'h22;
        send(32'h600, 32'h20, 8'd5);
        wait_done(at);
        chk("t3_done_cyc", at, 7);
        chk("t3_err", err_cnt, 1);
        corrupt_en = 1'b0;
        repeat (3) tick();
        chk("t3_err_hold", err_cnt, 1);
        chk("t3_ready", bus.cmd_ready, 1);

        // Response stall: only FIFO_DEPTH beats go out until responses return.
        hold = 1'b1;
        base = issued;
        send(32'h300, 32'h40, 8'd8);
        chk("t4_err_cleared", err_cnt, 0);
        repeat (4) tick();
        chk("t4_stall_en", bus.dadd_in_en, 0);
        repeat (3) tick();
        chk("t4_issued_held", issued - base, 4);
        hold = 1'b0;
        wait_done(at);
        chk("t4_done_seen", (at > 8) ? 1 : 0, 1);
        chk("t4_issued_all", issued - base, 8);
        chk("t4_err", err_cnt, 0);
        chk("t4_tmo", timeout_err, 0);
        tick();

        // Timeout: every response dropped.
        drop = 1'b1;
        send(32'h700, 32'h1, 8'd2);
        wait_done(at);
        chk("t5_done_cyc", at, 17);
        chk("t5_tmo", timeout_err, 1);
        chk("t5_err", err_cnt, 0);
        tick();
        chk("t5_ready", bus.cmd_ready, 1);
        chk("t5_tmo_hold", timeout_err, 1);
        drop = 1'b0;
        tick();

        // Zero-length command completes in cycle 1 and clears the timeout flag.
        send(32'h800, 32'h5, 8'd0);
        chk("t6_no_beat", bus.dadd_in_en, 0);
        wait_done(at);
        chk("t6_done_cyc", at, 1);
        chk("t6_tmo_cleared", timeout_err, 0);
        tick();
        chk("t6_ready", bus.cmd_ready, 1);

        // Reset in cycle 3 of a len=10 burst.
        send(32'h400, 32'h80, 8'd10);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        chk_reset_outs("t7_rst");
        rst_n = 1'b1;
        dn = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (done) dn++;
        end
        chk("t7_no_done", dn, 0);
        send(32'h500, 32'h7, 8'd1);
        chk("t7_data", bus.dadd_in, 32'h7);
        chk("t7_addr", bus.dadd_in_addr, 32'h500);
        wait_done(at);
        chk("t7_done_cyc", at, 3);
        chk("t7_err", err_cnt, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
